fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of decode/issue in the SimpleOOO core.
- Owns the architectural fetch PC and reads instruction memory combinationally, one instruction per cycle.
- Buffers fetched instructions and their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a redirect from branch resolution that flushes the FIFO and restarts fetch at the supplied PC.

Parameters:
- PC_W, 3, PC / instruction-memory address width; instruction memory holds 2^PC_W words.
- INST_W, 16, instruction word width.
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- imem_addr  output  PC_W  fetch address; always equals internal pc
- imem_rdata  input  INST_W  instruction word at imem_addr, valid in the same cycle
- out_valid  output  1  head entry valid toward decode
- out_ready  input  1  decode accepts head this cycle
- out_inst  output  INST_W  head instruction
- out_pc  output  PC_W  PC of head instruction
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  PC_W  restart PC
- full  output  1  count == DEPTH

Behaviour:
- State:
  - pc register.
  - FIFO storage of {pc, inst} entries.
  - head and tail pointers, log2(DEPTH) bits each, wrapping mod DEPTH.
  - count, log2(DEPTH)+1 bits.
- Reset (rst high at a clock edge):
  - pc=0, head=0, tail=0, count=0.
  - Hence out_valid=0, full=0.
  - out_inst and out_pc are don't-care while out_valid=0.
  - Reset overrides all other inputs. Reset asserted mid-operation discards all entries.
- pop = out_valid & out_ready.
- out_valid = (count != 0) & ~redirect_valid. This is the only combinational input-to-output path; it prevents decode from consuming a wrong-path entry.
- out_inst and out_pc are driven from the head entry register; no combinational path from imem_rdata.
- push = ~redirect_valid & ((count < DEPTH) | pop).
  - A full queue can accept a push in the same cycle as a pop.
- On push:
  - Write {pc, imem_rdata} at tail; tail <= tail+1.
  - pc <= pc+1, wrapping mod 2^PC_W (7+1 -> 0 at PC_W=3).
- On pop: head <= head+1.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push and pop together.
- When push is blocked because the queue is full with no pop, pc holds and the same address is re-presented next cycle.
- Redirect priority: redirect_valid beats push and pop. In a redirect cycle:
  - no handshake completes;
  - head=0, tail=0, count=0;
  - pc <= redirect_pc.
  - The next cycle fetches redirect_pc, and that instruction is visible at out one cycle after that.
  - Back-to-back redirects: the last one wins.
- Latency:
  - Fetch to out_valid: 1 cycle when the queue is empty.
  - First instruction after reset release: memi[0] is fetched in the first non-reset cycle and out_valid rises in the second.
- Throughput: 1 instruction per cycle sustained with out_ready held high.
- Instructions pass through unmodified; no decode is done in this block.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, the block adds two output ports and two counters:
  - perf_fetched, 16 bits: counts push cycles.
  - perf_flushed, 16 bits: each redirect cycle adds the count value held at that edge.
  - Both counters reset to 0 on rst and wrap at 2^16.
- When undefined:
  - neither the ports nor the counter logic exist;
  - all other behaviour is identical.

Test Plan:
- Reset, then out_ready=1 with imem returning 16'hA000+addr. Required:
  - cycle 1 after reset release: out_valid=0;
  - cycle 2: out_pc=0, out_inst=16'hA000;
  - then one entry per cycle with out_pc 1,2,...,7, then 0 again (PC wrap).
- out_ready=0 from reset release. Required:
  - full=1 after 4 cycles;
  - imem_addr holds at 4;
  - after raising out_ready, entries with pc 0,1,2,3 appear in order, then 4; none lost or duplicated.
- Queue full (pc 0..3 held) with out_ready=1 for one cycle. Required:
  - pop and push in the same cycle;
  - count stays 4;
  - pc advances 4 -> 5.
- Two entries queued, redirect_valid=1, redirect_pc=6, out_ready=1. Required:
  - out_valid=0 in the redirect cycle;
  - count=0 next cycle;
  - imem_addr=6 next cycle;
  - the cycle after that, out_pc=6.
- Redirect in the cycle right after reset release with redirect_pc=3. Required: first delivered out_pc=3; pc 0 is never delivered.
- With FETCH_PERF_CNT_EN: run 5 pushes, then redirect with 2 entries queued. Required: perf_fetched=5, perf_flushed=2.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding decode.
// Owns the fetch PC, reads instruction memory combinationally (one word per
// cycle), buffers {pc, inst} pairs in a small FIFO and hands them to decode
// over a valid/ready handshake. A redirect flushes the FIFO and restarts
// fetch at redirect_pc.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr  / imem_rdata  instruction memory address (== pc) / read data
//   out_valid / out_ready    decode handshake (out_valid masked by redirect)
//   out_inst / out_pc        head entry of the FIFO
//   redirect_valid / _pc     flush and restart fetch
//   full                     FIFO holds DEPTH entries
//   perf_fetched/_flushed    only when FETCH_PERF_CNT_EN is defined
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds two 16-bit perf counters).
module fetch_queue #(
    parameter int unsigned PC_W   = 3,
    parameter int unsigned INST_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              full
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushed
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic pop;
    logic push;
    logic not_empty;

    // Handshake: redirect masks valid so decode never takes a wrong-path entry.
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = not_empty & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = ~redirect_valid & (~full | pop);

    assign imem_addr = pc_q;
    assign out_inst  = inst_mem_q[head_q];
    assign out_pc    = pc_mem_q[head_q];

    // Next-state for pc, pointers and occupancy; redirect beats push/pop.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
                pc_d   = pc_q + PC_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until referenced by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]   <= pc_q;
            inst_mem_q[tail_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_flushed_q, perf_flushed_d;

    // Fetched counts push cycles; flushed accumulates entries discarded by redirects.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        if (push && !rst) begin
            perf_fetched_d = perf_fetched_q + 16'(1);
        end
        if (redirect_valid && !rst) begin
            perf_flushed_d = perf_flushed_q + 16'(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
